sobel_magnitude_iter: RTL and testbench

//  Parametrised Sobel gradient-magnitude unit. Takes signed vertical/horizontal gradients, computes

---
 rtl/sobel_magnitude_iter.sv | 132 +++++++++++++
 tb/tb_sobel_magnitude_iter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_magnitude_iter.sv
// Sobel gradient magnitude: L2 via bit-serial sqrt, L1, or max+min/2.
// One sample in flight; output saturates to OUT_W bits.
module sobel_magnitude_iter #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  vert_in,
    input  logic [IN_W-1:0]  horz_in,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_mag,
    output logic             out_sat
);

    localparam int CW = $clog2(IN_W + 1);
    localparam logic [IN_W:0] MAXV = {{(IN_W + 1 - OUT_W){1'b0}}, {OUT_W{1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_SQRT,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CW-1:0]     r_cnt;
    logic [2*IN_W-1:0] r_rad;
    logic [IN_W-1:0]   r_root;
    logic [IN_W+1:0]   r_rem;
    logic [OUT_W-1:0]  r_mag;
    logic              r_sat;

    logic              w_accept;
    logic              w_last;
    logic [IN_W-1:0]   w_av;
    logic [IN_W-1:0]   w_ah;
    logic [IN_W-1:0]   w_mx;
    logic [IN_W-1:0]   w_mn;
    logic [2*IN_W-1:0] w_rad;
    logic [IN_W:0]     w_l1;
    logic [IN_W:0]     w_mm;
    logic [IN_W:0]     w_fast;
    logic [IN_W+1:0]   w_rem_sh;
    logic [IN_W+1:0]   w_trial;
    logic              w_ge;
    logic [IN_W+1:0]   w_rem_nx;
    logic [IN_W-1:0]   w_root_nx;

    function automatic logic [OUT_W:0] sat_f(input logic [IN_W:0] raw);
        if (raw > MAXV)
            return {1'b1, {OUT_W{1'b1}}};
        return {1'b0, raw[OUT_W-1:0]};
    endfunction

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign out_mag   = r_mag;
    assign out_sat   = r_sat;
    assign w_accept  = in_valid & in_ready;
    assign w_last    = (r_cnt == CW'(IN_W - 1));

    // Two's-complement negate of the most negative value yields 2^(IN_W-1) unsigned
    assign w_av   = vert_in[IN_W-1] ? -vert_in : vert_in;
    assign w_ah   = horz_in[IN_W-1] ? -horz_in : horz_in;
    assign w_mx   = (w_av >= w_ah) ? w_av : w_ah;
    assign w_mn   = (w_av >= w_ah) ? w_ah : w_av;
    assign w_rad  = {{IN_W{1'b0}}, w_av} * {{IN_W{1'b0}}, w_av}
                  + {{IN_W{1'b0}}, w_ah} * {{IN_W{1'b0}}, w_ah};
    assign w_l1   = {1'b0, w_av} + {1'b0, w_ah};
    assign w_mm   = {1'b0, w_mx} + ({1'b0, w_mn} >> 1);
    assign w_fast = (mode == 2'd2) ? w_mm : w_l1;

    // Restoring digit step: bring down two radicand bits, try (4*root+1)
    assign w_rem_sh  = (IN_W + 2)'({r_rem, r_rad[2*IN_W-1 -: 2]});
    assign w_trial   = {r_root, 2'b01};
    assign w_ge      = (w_rem_sh >= w_trial);
    assign w_rem_nx  = w_ge ? (w_rem_sh - w_trial) : w_rem_sh;
    assign w_root_nx = (r_root << 1) | IN_W'(w_ge);

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (w_accept)
                w_next = (mode == 2'd0) ? S_SQRT : S_DONE;
            S_SQRT: if (w_last)
                w_next = S_DONE;
            S_DONE: if (out_ready)
                w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_rad  <= '0;
            r_root <= '0;
            r_rem  <= '0;
            r_mag  <= '0;
            r_sat  <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (w_accept) begin
                r_rad  <= w_rad;
                r_root <= '0;
                r_rem  <= '0;
                r_cnt  <= '0;
                if (mode != 2'd0)
                    {r_sat, r_mag} <= sat_f(w_fast);
            end
        end else if (r_state == S_SQRT) begin
            r_rad  <= r_rad << 2;
            r_root <= w_root_nx;
            r_rem  <= w_rem_nx;
            r_cnt  <= r_cnt + CW'(1);
            if (w_last)
                {r_sat, r_mag} <= sat_f({1'b0, w_root_nx});
        end
    end

endmodule

// File: tb/tb_sobel_magnitude_iter.sv
// Randomized and directed bench for sobel_magnitude_iter against an
// arithmetic reference model (real sqrt refined to the integer floor).
module tb_sobel_magnitude_iter;

    localparam int IN_W  = 16;
    localparam int OUT_W = 8;
    localparam int MAXO  = (1 << OUT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  vert_in;
    logic [IN_W-1:0]  horz_in;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_mag;
    logic             out_sat;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sobel_magnitude_iter #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .vert_in(vert_in), .horz_in(horz_in), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_mag(out_mag), .out_sat(out_sat)
    );

    task automatic ref_model(input int v, input int h, input int m,
                             output int mag, output int sat);
        longint av, ah, rr, r, raw;
        av = (v < 0) ? -v : v;
        ah = (h < 0) ? -h : h;
        if (m == 0) begin
            rr = av * av + ah * ah;
            r  = longint'($floor($sqrt(real'(rr))));
            while (r * r > rr) r--;
            while ((r + 1) * (r + 1) <= rr) r++;
            raw = r;
        end else if (m == 2) begin
            raw = ((av > ah) ? av : ah) + (((av > ah) ? ah : av) / 2);
        end else begin
            raw = av + ah;
        end
        sat = (raw > MAXO) ? 1 : 0;
        mag = sat ? MAXO : int'(raw);
    endtask

    function automatic int rnd_grad();
        logic signed [IN_W-1:0] t;
        t = IN_W'($urandom);
        return int'(t >>> $urandom_range(0, IN_W - 1));
    endfunction

    // Drive one sample; lat = edges after the accept edge until out_valid
    task automatic do_op(input int v, input int h, input int m, input bit scramble,
                         output int mag, output int sat, output int lat, output bit tmo);
        @(negedge clk);
        in_valid = 1'b1;
        vert_in  = v[IN_W-1:0];
        horz_in  = h[IN_W-1:0];
        mode     = m[1:0];
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        tmo = 1'b0;
        while (!out_valid) begin
            if (scramble) begin
                vert_in = IN_W'($urandom);
                horz_in = IN_W'($urandom);
                mode    = 2'($urandom);
            end
            @(negedge clk);
            lat++;
            if (lat > 200) begin
                tmo = 1'b1;
                break;
            end
        end
        mag = int'(out_mag);
        sat = int'(out_sat);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_mag !== '0 || out_sat !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset: valid=%b mag=%0d sat=%b rdy=%b want 0 0 0 1",
                     out_valid, out_mag, out_sat, in_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic run_checked(input string name, input int v, input int h, input int m,
                               input bit scramble);
        int mag, sat, lat, emag, esat, elat;
        bit tmo;
        do_op(v, h, m, scramble, mag, sat, lat, tmo);
        ref_model(v, h, m, emag, esat);
        elat = (m == 0) ? IN_W : 0;
        checks++;
        if (tmo || mag != emag || sat != esat) begin
            errors++;
            $display("FAIL %s v=%0d h=%0d m=%0d: mag=%0d sat=%0d tmo=%b want mag=%0d sat=%0d",
                     name, v, h, m, mag, sat, tmo, emag, esat);
        end
        checks++;
        if (lat != elat) begin
            errors++;
            $display("FAIL %s_latency v=%0d h=%0d m=%0d: got %0d want %0d",
                     name, v, h, m, lat, elat);
        end
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_release: valid=%b rdy=%b want 0 1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_l2();
        int vs[5] = '{35, 244, 0, 255, 3};
        int hs[5] = '{35, 35, 0, 255, 4};
        for (int i = 0; i < 5; i++)
            run_checked("l2_directed", vs[i], hs[i], 0, 1'b0);
        for (int i = 0; i < 20; i++)
            run_checked("l2_random", rnd_grad(), rnd_grad(), 0, 1'b0);
        run_checked("l2_corner", -32768, -32768, 0, 1'b0);
    endtask

    task automatic test_fast_modes();
        int vs[4] = '{-100, -32768, 30, 3};
        int hs[4] = '{50, -32768, -40, -4};
        int ms[4] = '{1, 1, 2, 3};
        for (int i = 0; i < 4; i++)
            run_checked("fast_directed", vs[i], hs[i], ms[i], 1'b0);
        for (int i = 0; i < 30; i++)
            run_checked("fast_random", rnd_grad(), rnd_grad(), $urandom_range(1, 3), 1'b0);
    endtask

    task automatic test_backpressure();
        int emag, esat, nmag, nsat;
        ref_model(10, 20, 1, emag, esat);
        ref_model(1, 1, 1, nmag, nsat);
        @(negedge clk);
        in_valid = 1'b1;
        vert_in  = IN_W'(10);
        horz_in  = IN_W'(20);
        mode     = 2'd1;
        @(posedge clk);
        @(negedge clk);
        vert_in = IN_W'(1);
        horz_in = IN_W'(1);
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || int'(out_mag) != emag || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold: valid=%b mag=%0d rdy=%b want 1 %0d 0",
                         out_valid, out_mag, in_ready, emag);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_release: valid=%b rdy=%b want 0 1", out_valid, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || int'(out_mag) != nmag) begin
            errors++;
            $display("FAIL backpressure_next: valid=%b mag=%0d want 1 %0d", out_valid, out_mag, nmag);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        in_valid = 1'b1;
        vert_in  = IN_W'(1000);
        horz_in  = IN_W'(2000);
        mode     = 2'd0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_mag !== '0) begin
            errors++;
            $display("FAIL reset_mid: valid=%b rdy=%b mag=%0d want 0 1 0", out_valid, in_ready, out_mag);
        end
        rst_n = 1'b1;
        run_checked("after_reset", 3, 4, 0, 1'b0);
    endtask

    task automatic test_input_hold();
        run_checked("hold_l2", 6, 8, 0, 1'b1);
        for (int i = 0; i < 5; i++)
            run_checked("hold_random", rnd_grad(), rnd_grad(), 0, 1'b1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        vert_in   = '0;
        horz_in   = '0;
        mode      = 2'd0;
        test_reset();
        test_l2();
        test_fast_modes();
        test_backpressure();
        test_reset_mid();
        test_input_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
